// File: rtl/branch_predictor_ctrl_if.sv
// rtl/branch_predictor_ctrl_if.sv - fetch lookup, resolver feedback and status bundle for the branch predictor
interface branch_predictor_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  clear_in;
  logic                  fetch_valid_in;
  logic [DATA_WIDTH-1:0] fetch_pc_in;
  logic                  pred_valid_out;
  logic                  pred_out;
  logic                  fb_enable_in;
  logic [DATA_WIDTH-1:0] fb_pc_in;
  logic                  fb_taken_in;
  logic                  fb_flush_in;
  logic                  ready_out;

  modport master (
    output clear_in, fetch_valid_in, fetch_pc_in,
    output fb_enable_in, fb_pc_in, fb_taken_in, fb_flush_in,
    input  pred_valid_out, pred_out, ready_out
  );

  modport slave (
    input  clear_in, fetch_valid_in, fetch_pc_in,
    input  fb_enable_in, fb_pc_in, fb_taken_in, fb_flush_in,
    output pred_valid_out, pred_out, ready_out
  );
endinterface

// File: rtl/branch_predictor_ctrl.sv
// rtl/branch_predictor_ctrl.sv - bimodal 2-bit BHT with init sweep, 2-stage training and lookup bypass
// Optional statistics counters enabled by defining BRANCH_PRED_STATS_EN.
module branch_predictor_ctrl #(
  parameter int         DATA_WIDTH = 32,
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic        clk_in,
  input  logic        rst_in,
`ifdef BRANCH_PRED_STATS_EN
  output logic [31:0] stat_branches_out,
  output logic [31:0] stat_mispred_out,
`endif
  branch_predictor_ctrl_if.slave bus
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] PTR_ONE = 1;
  localparam logic [INDEX_BITS-1:0] PTR_MAX = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] ptr_q, ptr_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [INDEX_BITS-1:0] pend_idx_q, pend_idx_d;
  logic                  pend_taken_q, pend_taken_d;
  logic                  pred_valid_q, pred_valid_d;
  logic                  pred_q, pred_d;

  logic [1:0]            bht_q [ENTRIES];
  logic                  wr_en;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [1:0]            wr_data;
  logic [INDEX_BITS-1:0] fetch_idx, fb_idx;
  logic [1:0]            pend_cnt, pend_next;

  assign fetch_idx = bus.fetch_pc_in[INDEX_BITS+1:2];
  assign fb_idx    = bus.fb_pc_in[INDEX_BITS+1:2];

  always_comb begin
    pend_cnt = bht_q[pend_idx_q];
    if (pend_taken_q) pend_next = (pend_cnt == 2'd3) ? 2'd3 : pend_cnt + 2'd1;
    else              pend_next = (pend_cnt == 2'd0) ? 2'd0 : pend_cnt - 2'd1;
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    pend_valid_d = 1'b0;
    pend_idx_d   = pend_idx_q;
    pend_taken_d = pend_taken_q;
    pred_valid_d = 1'b0;
    pred_d       = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = pend_idx_q;
    wr_data      = pend_next;
    case (state_q)
      ST_INIT: begin
        wr_en   = 1'b1;
        wr_idx  = ptr_q;
        wr_data = INIT_STATE;
        if (bus.clear_in) begin
          ptr_d = '0;
        end else if (ptr_q == PTR_MAX) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PTR_ONE;
        end
      end
      default: begin
        wr_en = pend_valid_q;
        if (bus.fetch_valid_in) begin
          pred_valid_d = 1'b1;
          // The pending write lands on this same edge, so a matching lookup takes its result.
          if (pend_valid_q && pend_idx_q == fetch_idx) pred_d = pend_next[1];
          else                                         pred_d = bht_q[fetch_idx][1];
        end
        if (bus.clear_in) begin
          state_d = ST_INIT;
          ptr_d   = '0;
        end else if (bus.fb_enable_in) begin
          pend_valid_d = 1'b1;
          pend_idx_d   = fb_idx;
          pend_taken_d = bus.fb_taken_in;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= ST_INIT;
      ptr_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
      pend_taken_q <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
      pend_taken_q <= pend_taken_d;
      pred_valid_q <= pred_valid_d;
      pred_q       <= pred_d;
    end
  end

  // Table contents need no reset: every entry is rewritten by the sweep before RUN.
  always_ff @(posedge clk_in) begin
    if (wr_en) bht_q[wr_idx] <= wr_data;
  end

  assign bus.pred_valid_out = pred_valid_q;
  assign bus.pred_out       = pred_q;
  assign bus.ready_out      = (state_q == ST_RUN);

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.fetch_pc_in[DATA_WIDTH-1:INDEX_BITS+2], bus.fetch_pc_in[1:0],
                            bus.fb_pc_in[DATA_WIDTH-1:INDEX_BITS+2], bus.fb_pc_in[1:0]};

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (bus.clear_in) begin
      br_cnt_d = '0;
      mp_cnt_d = '0;
    end else if (state_q == ST_RUN && bus.fb_enable_in) begin
      if (br_cnt_q != 32'hFFFF_FFFF) br_cnt_d = br_cnt_q + 32'd1;
      if (bus.fb_flush_in && mp_cnt_q != 32'hFFFF_FFFF) mp_cnt_d = mp_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign stat_branches_out = br_cnt_q;
  assign stat_mispred_out  = mp_cnt_q;
`else
  logic unused_flush;
  assign unused_flush = bus.fb_flush_in;
`endif
endmodule

// File: doc/branch_predictor_ctrl.md
Name: branch_predictor_ctrl

Overview:
- Bimodal branch history table (BHT) of 2-bit saturating counters.
- Supplies the taken prediction that travels with a branch into the branch resolver.
- Trains on the resolver's feedback (enable, taken, flush).
- Owns table initialisation, clear sequencing and the read/update collision bypass between the fetch lookup and the issue-stage update.

Parameters:
- DATA_WIDTH, 32, address width of PC inputs.
- INDEX_BITS, 6, log2 of BHT entries; index = pc[INDEX_BITS+1:2].
- INIT_STATE, 2'b01, counter value written on init/clear (weakly not-taken).

Ports:
- clk_in  input  1  clock; all state on rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- clear_in  input  1  synchronous request to re-initialise the table.
- fetch_valid_in  input  1  lookup request this cycle.
- fetch_pc_in  input  DATA_WIDTH  PC of fetched instruction.
- pred_valid_out  output  1  prediction valid (one cycle after request).
- pred_out  output  1  predicted taken (counter bit 1).
- fb_enable_in  input  1  resolver feedback valid (a branch was resolved).
- fb_pc_in  input  DATA_WIDTH  PC of resolved branch.
- fb_taken_in  input  1  actual outcome.
- fb_flush_in  input  1  resolver reported a mispredict.
- ready_out  output  1  table initialised; lookups and updates accepted.

Behaviour:
- States: INIT, RUN. Async reset (rst_in=0) forces INIT, sweep pointer=0, pending-update register invalid, all outputs 0.
- INIT:
  - Writes INIT_STATE to entry[ptr] each cycle, ptr++.
  - Leaves for RUN on the cycle after ptr reaches 2^INDEX_BITS-1; total 2^INDEX_BITS cycles.
  - ready_out=0, pred_valid_out=0, pred_out=0.
  - Lookups and feedback are dropped, not queued.
- RUN:
  - ready_out=1.
  - clear_in=1 → INIT next cycle with ptr=0, pending update discarded.
  - clear_in in INIT restarts the sweep at ptr=0.
- Lookup, 1-cycle latency:
  - fetch_valid_in sampled at edge N.
  - At N+1: pred_valid_out=1, pred_out=counter[idx][1].
  - pred_valid_out=0 otherwise; pred_out holds 0 when not valid.
- Update, 2-stage:
  - fb_enable_in sampled into pending register {idx, taken} at edge N.
  - Entry written at edge N+1.
  - taken: counter=min(counter+1,3); not taken: max(counter-1,0). Saturating, never wraps.
- Bypass:
  - A lookup whose index equals the valid pending update index uses the post-update counter value.
  - Back-to-back updates to the same index chain correctly: second update sees first result.
- fb_flush_in: no table effect beyond the update; counted only (see option).
- Lookup and update to different indices in the same cycle proceed independently.
- Reset mid-sweep or mid-update: all state abandoned; full INIT rerun.

Optional Feature:
- Macro BRANCH_PRED_STATS_EN.
- Defined:
  - Adds outputs stat_branches_out[31:0] (count of fb_enable_in in RUN) and stat_mispred_out[31:0] (count of fb_enable_in & fb_flush_in).
  - Both saturate at 32'hFFFFFFFF.
  - Both cleared by reset and by clear_in.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- INDEX_BITS=4, reset released → ready_out=0 for exactly 16 cycles then 1; lookup pc=0x40 → pred_valid_out=1, pred_out=0 next cycle.
- Feedback pc=0x40 taken twice, then lookup 0x40 → pred_out=1 (counter 01→10→11); one not-taken → still 1 (10); second not-taken → 0 (01).
- Four not-taken on pc=0x8 → counter saturates at 00, no wrap; one taken → 01, pred_out=0.
- Feedback taken on pc=0x40 at edge N with counter 01, lookup 0x40 at edge N+1 → pred_out=1 via bypass; lookup pc=0x44 at N+1 → unaffected.
- clear_in in RUN after training entry 0x40 to 11 → ready_out=0 for 16 cycles, then lookup 0x40 → pred_out=0; feedback during INIT ignored.
- With BRANCH_PRED_STATS_EN: 5 resolutions, 2 with fb_flush_in → stat_branches_out=5, stat_mispred_out=2; rst_in low mid-sweep → both 0, sweep restarts.
